// File: rtl/op_dispatcher.sv
// op_dispatcher: queues 20-bit opcode entries and issues them one at a time to an executor
// using a Done handshake, with a programmable idle gap between consecutive issues.
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          asynchronous active-low reset
//   load_en_i       push load_word_i into the queue (accepted in every state)
//   load_word_i     [19:16] op, [15:8] select/destination, [7:0] operand
//   start_i         begin dispatch from IDLE (ignored while busy)
//   abort_i         return to IDLE on the next edge, dropping the in-flight opcode
//   done_i          level completion flag from the executor
//   op_code_o       registered opcode presented to the executor, 0 when not issuing
//   busy_o          high in every state except IDLE
//   empty_o/full_o  queue occupancy flags
//   overflow_o      sticky: a push was attempted while full
//   issued_count_o  opcodes completed since reset, wrapping
module op_dispatcher #(
   parameter int Depth     = 16,
   parameter int GapCycles = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_en_i,
   input  logic [19:0] load_word_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        done_i,
   output logic [19:0] op_code_o,
   output logic        busy_o,
   output logic        empty_o,
   output logic        full_o,
   output logic        overflow_o,
   output logic [7:0]  issued_count_o
);
   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RELEASE, GAP} state_e;
   state_e      state_q, state_d;
   logic [19:0] mem_q [Depth];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [19:0] op_code_q, op_code_d, head;
   logic [3:0]  gap_q, gap_d;
   logic [7:0]  issued_q, issued_d;
   logic        overflow_q, pop, push;
   assign head           = mem_q[rd_ptr_q];
   assign empty_o        = count_q == '0;
   assign full_o         = count_q == CW'(Depth);
   // A pop in the same cycle frees a slot, so a push while full still lands.
   assign push           = load_en_i & (~full_o | pop);
   assign busy_o         = state_q != IDLE;
   assign op_code_o      = op_code_q;
   assign overflow_o     = overflow_q;
   assign issued_count_o = issued_q;
   always_comb begin
      state_d   = state_q;
      op_code_d = '0;
      gap_d     = gap_q;
      issued_d  = issued_q;
      pop       = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = start_i ? FETCH : IDLE;
            FETCH: begin
               if (empty_o) begin
                  state_d = IDLE;
               end else begin
                  pop = 1'b1;
                  // op field 0 marks a halt entry: consumed but never driven
                  if (head[19:16] == 4'd0) begin
                     state_d = IDLE;
                  end else begin
                     state_d   = ISSUE;
                     op_code_d = head;
                  end
               end
            end
            ISSUE: begin
               if (done_i) begin
                  state_d  = RELEASE;
                  issued_d = issued_q + 8'd1;
               end else begin
                  op_code_d = op_code_q;
               end
            end
            RELEASE: begin
               if (!done_i) begin
                  state_d = GAP;
                  gap_d   = 4'(GapCycles - 1);
               end
            end
            GAP: begin
               state_d = (gap_q == 4'd0) ? FETCH : GAP;
               gap_d   = (gap_q == 4'd0) ? gap_q : gap_q - 4'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         op_code_q  <= '0;
         gap_q      <= '0;
         issued_q   <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_code_q  <= op_code_d;
         gap_q      <= gap_d;
         issued_q   <= issued_d;
         overflow_q <= overflow_q | (load_en_i & full_o & ~pop);
         wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_q    <= count_q + CW'(push) - CW'(pop);
      end
   end
   // Storage needs no reset: the pointers and count define which words are live.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= load_word_i;
   end
endmodule

// File: tb/tb_op_dispatcher.sv
// tb_op_dispatcher: randomized and directed checks of op_dispatcher against a queue-based reference model.
module tb_op_dispatcher;
   localparam int DEPTH = 16;
   localparam int GAP   = 1;
   localparam int MI = 0, MW = 1, MS = 2, MR = 3;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        load_en = 1'b0, start = 1'b0, abort = 1'b0, done = 1'b0;
   logic [19:0] load_word = '0;
   logic [19:0] op_code;
   logic        busy, empty, full, ovf;
   logic [7:0]  issued;
   int errs = 0, checks = 0;
   int lat = 3, hold = 0, ecnt = 0;
   logic [19:0] mq[$];
   logic [19:0] log_q[$];
   logic [19:0] mop = '0, prev_op = '0, e;
   logic [7:0]  missued = '0;
   logic        movf = 1'b0, popped;
   int          mmode = MI, mcnt = 0, sz;
   op_dispatcher #(.Depth(DEPTH), .GapCycles(GAP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .load_en_i(load_en), .load_word_i(load_word),
      .start_i(start), .abort_i(abort), .done_i(done), .op_code_o(op_code),
      .busy_o(busy), .empty_o(empty), .full_o(full), .overflow_o(ovf),
      .issued_count_o(issued)
   );
   always #5 clk = ~clk;
   function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
      checks++;
      if (a !== x) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endfunction
   // Reference: a queue plus a phase (idle / waiting-to-fetch / issuing / releasing).
   // After Done falls the model waits GAP idle cycles, then spends one cycle fetching.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete(); mop = '0; missued = '0; movf = 1'b0; mmode = MI; mcnt = 0;
      end else begin
         sz = mq.size();
         popped = 1'b0;
         if (abort) begin
            mmode = MI; mop = '0;
         end else if (mmode == MI) begin
            if (start) begin mmode = MW; mcnt = 0; end
         end else if (mmode == MW) begin
            if (mcnt > 0) mcnt--;
            else if (sz == 0) mmode = MI;
            else begin
               e = mq.pop_front(); popped = 1'b1;
               if (e[19:16] == 4'd0) mmode = MI;
               else begin mop = e; mmode = MS; end
            end
         end else if (mmode == MS) begin
            if (done) begin mop = '0; missued++; mmode = MR; end
         end else if (!done) begin
            mmode = MW; mcnt = GAP;
         end
         if (load_en) begin
            if (sz < DEPTH || popped) mq.push_back(load_word);
            else movf = 1'b1;
         end
      end
   end
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("op", op_code, mop);
         chk("busy", busy, mmode != MI);
         chk("empty", empty, mq.size() == 0);
         chk("full", full, mq.size() == DEPTH);
         chk("ovf", ovf, movf);
         chk("issued", issued, missued);
         if (op_code != 0 && prev_op == 0) log_q.push_back(op_code);
         prev_op = op_code;
      end else prev_op = '0;
   end
   // Executor: raises Done lat cycles after an opcode appears, drops it hold cycles after OpCode clears.
   always @(negedge clk) begin
      if (!done) begin
         if (op_code != 0) begin
            if (ecnt >= lat - 1) begin done = 1'b1; ecnt = 0; end else ecnt++;
         end else ecnt = 0;
      end else if (op_code == 0) begin
         if (ecnt >= hold) begin done = 1'b0; ecnt = 0; end else ecnt++;
      end
   end
   task automatic push(input logic [19:0] w);
      load_en = 1'b1; load_word = w;
      @(negedge clk);
      load_en = 1'b0;
   endtask
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      log_q.delete();
   endtask
   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin @(negedge clk); n++; end
      if (busy) begin errs++; checks++; $display("FAIL wait_idle: busy=1 required 0 after %0d cycles", max); end
   endtask
   task automatic wait_log(input int cnt, input int max);
      int n = 0;
      while (log_q.size() < cnt && n < max) begin @(negedge clk); n++; end
      chk("wait_log", log_q.size(), cnt);
   endtask
   function automatic logic [19:0] rand_word();
      return {4'($urandom_range(1, 15)), 16'($urandom)};
   endfunction
   initial begin
      logic [19:0] exp_q[$];
      logic [19:0] w;
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [19:0] exp_q[$];
      logic [19:0] w;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_op", op_code, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_issued", issued, 0);
      // basic dispatch with halt marker
      push(20'h102AA); push(20'h1014A); push(20'h00000);
      log_q.delete();
      pulse_start();
      wait_idle(200);
      chk("basic_n", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("basic_0", log_q[0], 20'h102AA);
         chk("basic_1", log_q[1], 20'h1014A);
      end
      chk("basic_issued", issued, 2);
      chk("basic_empty", empty, 1);
      // fill past capacity, then drain in order
      do_reset();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin w = rand_word(); exp_q.push_back(w); push(w); end
      chk("fill_full", full, 1);
      chk("fill_ovf0", ovf, 0);
      push(rand_word());
      chk("fill_ovf1", ovf, 1);
      chk("fill_full2", full, 1);
      pulse_start();
      wait_idle(2000);
      chk("drain_n", log_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < log_q.size(); i++) chk("drain_order", log_q[i], exp_q[i]);
      chk("drain_empty", empty, 1);
      // Done held high after completion
      do_reset();
      lat = 2; hold = 5;
      push(20'h3A001); push(20'h4B002);
      pulse_start();
      wait_idle(300);
      chk("hold_n", log_q.size(), 2);
      chk("hold_issued", issued, 2);
      lat = 3; hold = 0;
      // abort during ISSUE of the second entry
      do_reset();
      push(20'h51111); push(20'h62222); push(20'h73333);
      pulse_start();
      wait_log(2, 200);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_op", op_code, 0);
      chk("abort_busy", busy, 0);
      chk("abort_issued", issued, 1);
      chk("abort_empty", empty, 0);
      pulse_start();
      wait_idle(200);
      chk("resume_n", log_q.size(), 3);
      if (log_q.size() == 3) chk("resume_2", log_q[2], 20'h73333);
      chk("resume_issued", issued, 2);
      // push during FETCH pop while full
      do_reset();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin w = rand_word(); exp_q.push_back(w); push(w); end
      pulse_start();
      w = rand_word(); exp_q.push_back(w);
      push(w);
      chk("fp_full", full, 1);
      chk("fp_ovf", ovf, 0);
      wait_idle(2000);
      chk("fp_n", log_q.size(), DEPTH + 1);
      if (log_q.size() == DEPTH + 1) chk("fp_last", log_q[DEPTH], w);
      // asynchronous reset mid-ISSUE
      push(rand_word()); push(rand_word()); push(rand_word());
      pulse_start();
      wait_log(DEPTH + 2, 200);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_op", op_code, 0);
      chk("arst_busy", busy, 0);
      chk("arst_empty", empty, 1);
      chk("arst_issued", issued, 0);
      @(negedge clk);
      rst_n = 1'b1;
      log_q.delete();
      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) begin lat = $urandom_range(1, 5); hold = $urandom_range(0, 4); end
         load_en   = ($urandom_range(0, 9) < 3);
         load_word = ($urandom_range(0, 15) == 0) ? {4'd0, 16'($urandom)} : rand_word();
         start     = ($urandom_range(0, 9) == 0);
         abort     = ($urandom_range(0, 59) == 0);
         @(negedge clk);
      end
      load_en = 1'b0; start = 1'b0; abort = 1'b0;
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/op_dispatcher.md
OP_DISPATCHER -- requirements
Module: op_dispatcher

Interface
REQ-001 Parameter Depth, default 16, number of queued opcode entries (power of two, 2..256).
REQ-002 Parameter GapCycles, default 1, number of idle cycles with OpCode=0 between consecutive issues (1..15).
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 LoadEn  input  1  push LoadWord into the queue this cycle.
REQ-006 LoadWord  input  20  opcode entry: [19:16] op, [15:8] select/destination, [7:0] operand.
REQ-007 Start  input  1  single-cycle pulse that begins dispatch from IDLE.
REQ-008 Abort  input  1  stops dispatch; has priority over Start.
REQ-009 Done  input  1  level completion flag from the executor.
REQ-010 OpCode  output  20  registered opcode presented to the executor; 0 when not issuing.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Empty  output  1  queue holds no entries.
REQ-013 Full  output  1  queue holds Depth entries.
REQ-014 Overflow  output  1  sticky flag: a push was attempted while Full.
REQ-015 IssuedCount  output  8  number of opcodes completed since reset; wraps 255->0.

Function
REQ-016 The queue SHALL be a FIFO of Depth x 20 bits with independent read/write pointers and an occupancy count.
REQ-017 A push while Full SHALL be dropped and SHALL set Overflow; queue contents and count stay unchanged.
REQ-018 A push and a pop in the same cycle SHALL both occur, leaving the count unchanged, including when Full.
REQ-019 LoadEn SHALL be accepted in every state, including during dispatch.
REQ-020 The state machine SHALL have the states IDLE, FETCH, ISSUE, RELEASE and GAP.
REQ-021 IDLE: OpCode=0; on Start with Abort low, go to FETCH; when Start arrives while Empty, go to FETCH, which returns to IDLE.
REQ-022 FETCH: if Empty, go to IDLE; else pop the head entry.
REQ-023 FETCH: if the popped entry has op[19:16]=0, the entry is a halt marker, is discarded, and the next state is IDLE.
REQ-024 FETCH: for any other popped entry, register it onto OpCode and go to ISSUE; OpCode is valid the cycle after FETCH.
REQ-025 ISSUE: hold OpCode stable until Done is sampled high; then set OpCode=0, increment IssuedCount, and go to RELEASE.
REQ-026 RELEASE: hold OpCode=0 until Done is sampled low; then go to GAP.
REQ-027 GAP: hold OpCode=0 for GapCycles cycles (counter), then go to FETCH.
REQ-028 Minimum spacing: an opcode is never presented while Done is high from the previous opcode.
REQ-029 Done high in IDLE, FETCH or GAP SHALL be ignored.
REQ-030 Abort in any state SHALL force IDLE and OpCode=0 on the next edge.
REQ-031 An in-flight opcode cancelled by Abort SHALL not be counted or re-queued.
REQ-032 Abort SHALL leave queue contents unchanged.
REQ-033 Start while Busy SHALL be ignored.
REQ-034 Empty, Full and Busy SHALL be derived from registered state only, with no combinational path from inputs.

Reset
REQ-035 ResetN low SHALL immediately force state IDLE and OpCode=0.
REQ-036 ResetN low SHALL immediately clear the queue pointers and count, Overflow, IssuedCount and the gap counter.
REQ-037 After reset: Empty=1, Full=0, Busy=0, Overflow=0, IssuedCount=0.
REQ-038 Reset asserted mid-dispatch SHALL discard the in-flight opcode and all queued entries.
REQ-039 The first Start accepted after reset SHALL be the one sampled on the first rising edge with ResetN high.

Verification
REQ-040 Push 0x102AA, 0x1014A, 0x00000; pulse Start; executor model asserts Done 3 cycles after each issue -> OpCode shows 0x102AA then 0x1014A, each followed by >=1 cycle of 0; the halt entry is never driven; IssuedCount=2; Busy falls; Empty=1.
REQ-041 Push 17 entries with Depth=16 -> Full=1 after the 16th push, Overflow=1 after the 17th, and 16 entries drain in order.
REQ-042 Hold Done high for 5 cycles after completion -> OpCode stays 0 until Done is low plus GapCycles; the next opcode is then issued once.
REQ-043 Assert Abort while in ISSUE on the 2nd of 3 entries -> OpCode=0 next cycle, IssuedCount=1, 3rd entry still queued; Start resumes with the 3rd entry.
REQ-044 Assert ResetN low asynchronously mid-ISSUE -> OpCode=0 and Busy=0 before the next clock edge; Empty=1 and IssuedCount=0.
REQ-045 Push simultaneously with a FETCH pop while Full -> count stays Depth and Overflow stays 0.
